// File: rtl/qos_pkg.sv
// Shared constants, types and helpers for the weighted round-robin QoS read scheduler.
package qos_pkg;

    localparam int QUEUE_QUANTITY = 4;
    localparam int MAX_WEIGHT     = 64;
    localparam int WW             = $clog2(MAX_WEIGHT);
    localparam int SEL_W          = $clog2(QUEUE_QUANTITY);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef logic [WW-1:0]    weight_t;
    typedef logic [SEL_W-1:0] sel_t;

    // Successor of a queue index, wrapping to 0 after the last queue.
    function automatic sel_t wrap_inc(input sel_t q);
        return (int'(q) == QUEUE_QUANTITY - 1) ? '0 : sel_t'(int'(q) + 1);
    endfunction

endpackage

// File: rtl/qos_scheduler_if.sv
// Bus bundle between the scheduler, the VC FIFOs and the output FIFO.
interface qos_scheduler_if;
    import qos_pkg::*;

    logic                             enb;
    logic                             load_weights;
    logic [QUEUE_QUANTITY*WW-1:0]     weights;
    logic [QUEUE_QUANTITY-1:0]        buf_empty;
    logic                             out_almost_full;
    logic                             out_full;
    logic [QUEUE_QUANTITY-1:0]        rd_en;
    sel_t                             selector;
    sel_t                             mux_sel;
    logic                             wr_en_out;
    logic                             idle;

    modport master (
        input  enb, load_weights, weights, buf_empty, out_almost_full, out_full,
        output rd_en, selector, mux_sel, wr_en_out, idle
    );

    modport slave (
        output enb, load_weights, weights, buf_empty, out_almost_full, out_full,
        input  rd_en, selector, mux_sel, wr_en_out, idle
    );

endinterface

// File: rtl/qos_scheduler_rotate_prio_enc.sv
// Rotating priority encoder: first set request at or after start, wrapping around.
module rotate_prio_enc
    import qos_pkg::*;
(
    input  logic [QUEUE_QUANTITY-1:0] req,
    input  sel_t                      start,
    output logic                      found,
    output sel_t                      idx
);

    sel_t cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan from farthest to nearest so the candidate closest to start wins.
        for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
            cand = sel_t'((int'(start) + k) % QUEUE_QUANTITY);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/qos_scheduler.sv
// Weighted round-robin read scheduler sharing one output FIFO among the VC FIFOs.
module qos_scheduler
    import qos_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    qos_scheduler_if.master bus
);

    state_t                    state_q, state_d;
    sel_t                      sel_q, sel_d;
    sel_t                      last_q, last_d;
    sel_t                      mux_sel_q;
    sel_t                      next_q;
    sel_t                      search_start;
    weight_t                   credit_q, credit_d;
    weight_t                   weight_q [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [QUEUE_QUANTITY-1:0] rd_en;
    logic                      stall;
    logic                      found;
    logic                      wr_en_q;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            eligible[i] = !bus.buf_empty[i] && (weight_q[i] != '0);
    end

    assign stall        = !bus.enb || bus.out_almost_full || bus.out_full;
    assign search_start = wrap_inc(last_q);

    // The queue just served is reached last, after every other candidate.
    rotate_prio_enc u_enc (
        .req   (eligible),
        .start (search_start),
        .found (found),
        .idx   (next_q)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < QUEUE_QUANTITY; i++)
                weight_q[i] <= weight_t'(1);
        end else if (bus.load_weights) begin
            for (int i = 0; i < QUEUE_QUANTITY; i++)
                weight_q[i] <= bus.weights[i*WW +: WW];
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        credit_d = credit_q;
        rd_en    = '0;
        case (state_q)
            IDLE: begin
                if (!stall && found) begin
                    state_d  = SERVE;
                    sel_d    = next_q;
                    last_d   = next_q;
                    credit_d = weight_q[next_q];
                end
            end
            SERVE: begin
                if (!stall) begin
                    if (!bus.buf_empty[sel_q]) begin
                        rd_en[sel_q] = 1'b1;
                        if (credit_q != '0)
                            credit_d = credit_q - weight_t'(1);
                    end
                    // Turn ends on an empty queue or when the last credit was just spent.
                    if (bus.buf_empty[sel_q] || credit_q <= weight_t'(1)) begin
                        if (found) begin
                            sel_d    = next_q;
                            last_d   = next_q;
                            credit_d = weight_q[next_q];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= sel_t'(QUEUE_QUANTITY - 1);
            credit_q  <= '0;
            wr_en_q   <= 1'b0;
            mux_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            credit_q  <= credit_d;
            wr_en_q   <= |rd_en;
            mux_sel_q <= sel_q;
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.selector  = sel_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.wr_en_out = wr_en_q;
    assign bus.idle      = (state_q == IDLE) && !wr_en_q;

endmodule

// File: tb/tb_qos_scheduler.sv
// Scoreboard bench for qos_scheduler: VC FIFO occupancy model plus expected write order.
module tb_qos_scheduler;
    import qos_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qos_scheduler_if bus();

    qos_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int loaded   [QUEUE_QUANTITY] = '{default: 0};
    int consumed [QUEUE_QUANTITY] = '{default: 0};
    int exp_q [$];
    int rd_cyc [$];
    int cyc = 0;
    logic [QUEUE_QUANTITY-1:0] prev_rd = '0;

    // VC FIFO model: occupancy = loaded - consumed, reads retire on the clock edge.
    always_comb begin
        bus.buf_empty = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            bus.buf_empty[i] = (consumed[i] >= loaded[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            if (bus.rd_en[i] === 1'b1)
                consumed[i] <= consumed[i] + 1;
    end

    // Output side: every write is popped against the expected queue order.
    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b0) begin
                prev_rd = '0;
            end else begin
                if (bus.rd_en !== '0) begin
                    rd_cyc.push_back(cyc);
                    checks++;
                    if (!$onehot(bus.rd_en) || (bus.rd_en & bus.buf_empty) !== '0) begin
                        errors++;
                        $display("FAIL rd_en_legal: got rd_en=%b with buf_empty=%b, required one-hot on a non-empty queue",
                                 bus.rd_en, bus.buf_empty);
                    end
                end
                if (bus.wr_en_out !== 1'b0 || prev_rd !== '0) begin
                    checks++;
                    if (bus.wr_en_out !== (prev_rd != '0)) begin
                        errors++;
                        $display("FAIL wr_align: got wr_en_out=%b, required %b (rd_en one cycle earlier was %b)",
                                 bus.wr_en_out, (prev_rd != '0), prev_rd);
                    end
                end
                if (bus.wr_en_out === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got write with mux_sel=%0d, required no write", bus.mux_sel);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.mux_sel !== sel_t'(e)) begin
                            errors++;
                            $display("FAIL sb_order: got mux_sel=%0d, required %0d", bus.mux_sel, e);
                        end
                    end
                end
                prev_rd = bus.rd_en;
            end
        end
    end

    task automatic setup(input int w0, input int w1, input int w2, input int w3,
                         input int n0, input int n1, input int n2, input int n3);
        @(posedge clk); #1;
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            loaded[i] = consumed[i];
        bus.weights      = {weight_t'(w3), weight_t'(w2), weight_t'(w1), weight_t'(w0)};
        bus.load_weights = 1'b1;
        @(posedge clk); #1;
        bus.load_weights = 1'b0;
        rd_cyc.delete();
        loaded[0] = consumed[0] + n0;
        loaded[1] = consumed[1] + n1;
        loaded[2] = consumed[2] + n2;
        loaded[3] = consumed[3] + n3;
    endtask

    task automatic wait_read(output logic [QUEUE_QUANTITY-1:0] seen);
        seen = '0;
        for (int n = 0; n < 50 && seen == '0; n++) begin
            @(posedge clk); #1;
            seen = bus.rd_en;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (!(bus.idle === 1'b1 && exp_q.size() == 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d expected writes still outstanding, required 0", name, exp_q.size());
        end
        checks++;
        if (bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: got idle=%b, required 1", name, bus.idle);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [QUEUE_QUANTITY-1:0] r;
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            loaded[i] = consumed[i] + 1;
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            exp_q.push_back(i);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rd_en !== '0) begin
            errors++; $display("FAIL reset_rd_en: got %b, required 0", bus.rd_en);
        end
        checks++;
        if (bus.wr_en_out !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en_out: got %b, required 0", bus.wr_en_out);
        end
        checks++;
        if (bus.selector !== '0) begin
            errors++; $display("FAIL reset_selector: got %0d, required 0", bus.selector);
        end
        checks++;
        if (bus.mux_sel !== '0) begin
            errors++; $display("FAIL reset_mux_sel: got %0d, required 0", bus.mux_sel);
        end
        checks++;
        if (bus.idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle: got %b, required 1", bus.idle);
        end
        rst = 1'b0;
        wait_read(r);
        checks++;
        if (r !== 4'b0001) begin
            errors++; $display("FAIL reset_first_read: got rd_en=%b, required 0001", r);
        end
        drain("reset");
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < QUEUE_QUANTITY; i++)
                exp_q.push_back(i);
        setup(1, 1, 1, 1, 3, 3, 3, 3);
        drain("rr");
        checks++;
        if (rd_cyc.size() != 12) begin
            errors++; $display("FAIL rr_read_count: got %0d reads, required 12", rd_cyc.size());
        end else begin
            checks++;
            if (rd_cyc[11] - rd_cyc[0] != 11) begin
                errors++; $display("FAIL rr_back_to_back: got reads spread over %0d cycles, required 12",
                                   rd_cyc[11] - rd_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_weighted();
        int pat [6];
        pat[0] = 0; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 3; pat[5] = 3;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 6; j++)
                exp_q.push_back(pat[j]);
        setup(3, 1, 0, 2, 9, 3, 5, 6);
        drain("weighted");
        checks++;
        if (loaded[2] - consumed[2] != 5) begin
            errors++; $display("FAIL weighted_q2_untouched: got %0d entries left, required 5",
                               loaded[2] - consumed[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [QUEUE_QUANTITY-1:0] r;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        setup(3, 1, 1, 1, 3, 1, 0, 0);
        wait_read(r);
        checks++;
        if (r !== 4'b0001) begin
            errors++; $display("FAIL bp_first_read: got rd_en=%b, required 0001", r);
        end
        @(posedge clk); #1;
        bus.out_almost_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.rd_en !== '0) begin
                errors++; $display("FAIL bp_stall_%0d: got rd_en=%b, required 0000", k, bus.rd_en);
            end
            @(posedge clk); #1;
        end
        bus.out_almost_full = 1'b0;
        #1;
        checks++;
        if (bus.rd_en !== 4'b0001) begin
            errors++; $display("FAIL bp_resume_1: got rd_en=%b, required 0001", bus.rd_en);
        end
        @(posedge clk); #2;
        checks++;
        if (bus.rd_en !== 4'b0001) begin
            errors++; $display("FAIL bp_resume_2: got rd_en=%b, required 0001", bus.rd_en);
        end
        @(posedge clk); #2;
        checks++;
        if (bus.rd_en !== 4'b0010) begin
            errors++; $display("FAIL bp_next_queue: got rd_en=%b, required 0010", bus.rd_en);
        end
        drain("bp");
    endtask

    task automatic test_empty_mid_turn();
        logic [QUEUE_QUANTITY-1:0] r;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        setup(4, 1, 1, 1, 2, 1, 0, 0);
        wait_read(r);
        checks++;
        if (r !== 4'b0001) begin
            errors++; $display("FAIL empty_read_1: got rd_en=%b, required 0001", r);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rd_en !== 4'b0001) begin
            errors++; $display("FAIL empty_read_2: got rd_en=%b, required 0001", bus.rd_en);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rd_en !== 4'b0000) begin
            errors++; $display("FAIL empty_bubble: got rd_en=%b, required 0000", bus.rd_en);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rd_en !== 4'b0010) begin
            errors++; $display("FAIL empty_switch: got rd_en=%b, required 0010", bus.rd_en);
        end
        drain("empty");
    endtask

    task automatic test_reset_mid_serve();
        logic [QUEUE_QUANTITY-1:0] r;
        setup(1, 1, 5, 1, 0, 0, 10, 0);
        wait_read(r);
        checks++;
        if (r !== 4'b0100) begin
            errors++; $display("FAIL rms_serving_q2: got rd_en=%b, required 0100", r);
        end
        // Reset lands while queue 2 is mid-turn; its in-flight write must vanish.
        rst = 1'b1;
        loaded[0] = consumed[0] + 1;
        exp_q.push_back(0);
        for (int k = 0; k < 9; k++)
            exp_q.push_back(2);
        @(posedge clk); #1;
        checks++;
        if (bus.wr_en_out !== 1'b0) begin
            errors++; $display("FAIL rms_wr_dropped: got wr_en_out=%b, required 0", bus.wr_en_out);
        end
        checks++;
        if (bus.rd_en !== '0 || bus.selector !== '0 || bus.mux_sel !== '0 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL rms_outputs: got rd_en=%b selector=%0d mux_sel=%0d idle=%b, required 0000/0/0/1",
                     bus.rd_en, bus.selector, bus.mux_sel, bus.idle);
        end
        rst = 1'b0;
        wait_read(r);
        checks++;
        if (r !== 4'b0001) begin
            errors++; $display("FAIL rms_restart_q0: got rd_en=%b, required 0001", r);
        end
        drain("rms");
    endtask

    initial begin
        bus.enb             = 1'b1;
        bus.load_weights    = 1'b0;
        bus.weights         = '0;
        bus.out_almost_full = 1'b0;
        bus.out_full        = 1'b0;
        test_reset();
        test_round_robin();
        test_weighted();
        test_backpressure();
        test_empty_mid_turn();
        test_reset_mid_serve();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qos_scheduler.md
Name: qos_scheduler

Overview:
Weighted round-robin read scheduler for the QoS datapath. It shares the single output FIFO among QUEUE_QUANTITY virtual-channel FIFOs. It issues one-hot read strobes to the VC FIFOs, drives the output mux select, and produces the aligned write strobe into the output FIFO. It honours per-queue weights and output-FIFO backpressure, and never reads an empty FIFO.

Parameters:
QUEUE_QUANTITY, 4, number of VC FIFOs served
MAX_WEIGHT, 64, weight range; weight width WW = $clog2(MAX_WEIGHT) = 6, so max weight is 63
SEL_W, $clog2(QUEUE_QUANTITY), selector width (derived, not overridable)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
enb  in  1  global enable; low acts as stall
load_weights  in  1  pulse; latch weights
weights  in  QUEUE_QUANTITY*WW  per-queue weights; queue i at [i*WW +: WW]
buf_empty  in  QUEUE_QUANTITY  empty flags of VC FIFOs
out_almost_full  in  1  output FIFO almost full
out_full  in  1  output FIFO full
rd_en  out  QUEUE_QUANTITY  one-hot VC FIFO read strobe
selector  out  SEL_W  queue currently being served
mux_sel  out  SEL_W  selector delayed 1 cycle; aligned with wr_en_out
wr_en_out  out  1  output FIFO write strobe
idle  out  1  no service in progress or in flight

Behaviour:
- Reset values: state=IDLE, selector=0, mux_sel=0, rd_en=0, wr_en_out=0, credit=0, weight_reg[i]=1 for all i, last=QUEUE_QUANTITY-1, idle=1. The first search therefore starts at queue 0.
- Weights: weight_reg loads from weights on any cycle with load_weights=1, in any state. A load does not alter the running credit; new values apply at the next credit load.
- eligible[i] = !buf_empty[i] && weight_reg[i]!=0. Weight 0 disables a queue.
- stall = !enb || out_almost_full || out_full.
- next_q: first eligible queue scanning from last+1 upward, modulo QUEUE_QUANTITY. The current queue itself is checked last.
- States: IDLE, SERVE.
- IDLE transitions:
  - If !stall and any eligible: selector<=next_q, credit<=weight_reg[next_q], last<=next_q, go to SERVE. First read occurs 1 cycle after eligibility is seen.
  - Otherwise stay in IDLE.
- SERVE, per cycle:
  - stall: rd_en=0; state, credit and selector are held.
  - buf_empty[selector]=1: no read. If any eligible, reload selector/credit from next_q and stay in SERVE; else go to IDLE.
  - Otherwise: rd_en[selector]=1 and credit<=credit-1. If credit==1 (turn exhausted), reload from next_q, or go to IDLE if none is eligible. Else keep the queue.
- rd_en is combinational: SERVE && !stall && !buf_empty[selector]. It is never asserted on an empty FIFO, even when eligibility is stale.
- Stale empty flag: a queue whose last entry was just read may be re-selected once. This costs one bubble cycle and is legal.
- wr_en_out <= |rd_en; mux_sel <= selector. Both are registered, 1-cycle latency, matching the registered VC FIFO output.
- idle = (state==IDLE) && !wr_en_out.
- Reset mid-operation: the in-flight wr_en_out is dropped (0 the next cycle) and all state returns to reset values.
- Credit underflow is impossible: credit is only decremented when ≥1.

Decomposition:
- Package qos_pkg: QUEUE_QUANTITY, MAX_WEIGHT, derived WW/SEL_W, state encoding (IDLE=0, SERVE=1).
- One natural sub-module: rotate_prio_enc. Inputs: request vector and start index. Outputs: found flag and index. Purely combinational.
- The FSM, credit counter and weight registers stay in qos_scheduler.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all queues non-empty. Required: rd_en=0, wr_en_out=0, selector=0, mux_sel=0, idle=1. The first read after release goes to queue 0.
- Plain round-robin: weights {1,1,1,1}, 3 entries per queue, no stall. Required: rd_en one-hot order 0,1,2,3 repeated three times, 12 reads in 12 consecutive cycles. wr_en_out trails by 1 cycle with mux_sel equal to the prior selector. Ends with idle=1.
- Weighted: weights {3,1,0,2}, all queues deep. Required: repeating read pattern 0,0,0,1,3,3; queue 2 is never read.
- Backpressure: out_almost_full=1 for 4 cycles in the middle of queue 0's 3-read turn, after its first read. Required: rd_en=0 for those 4 cycles, then the remaining 2 reads on queue 0 before moving to queue 1.
- Empty mid-turn: queue 0 has weight 4 and 2 entries; queue 1 is non-empty. Required: reads q0, q0, one bubble cycle, then q1. No rd_en[0] while buf_empty[0]=1.
- Reset mid-SERVE: assert rst while serving queue 2. Required: the next cycle shows all outputs at reset values, wr_en_out=0, and the subsequent search restarts at queue 0.
